lii_rx_reassembler: RTL and testbench
=====================================

// Module: lii_rx_reassembler
// PURPOSE
//  Receive end of an LII phy channel. Accepts narrow PW-bit beats tagged with src/dst.
//  Drops beats not addressed to MY_ID, then reassembles NBEAT beats into one DW-bit word.
//  Presents each word on an AXI-Stream-style kernel input port.
//  Sits between the LII phy fabric and an HLS kernel that consumes words wider than one beat.
// PARAMETERS
//  PW     64      phy beat width (bits)
//  DW     384     kernel word width (bits); NBEAT = (DW+PW-1)/PW, a derived localparam
//  MY_ID  8'h01   destination id this block accepts
// PORTS
//  aclk              in   1      clock
//  arstn             in   1      asynchronous active-low reset
//  lii_in_tdata      in   PW     phy beat payload
//  lii_in_tvalid     in   1      beat valid
//  lii_in_tready     out  1      beat accepted when tvalid&tready
//  lii_in_src        in   8      source id of the beat
//  lii_in_dst        in   8      destination id of the beat
//  out_stream_tdata  out  DW     reassembled word
//  out_stream_tvalid out  1      word valid
//  out_stream_tready in   1      kernel accepts the word
//  out_src           out  8      src id locked by the word's first beat
//  drop_cnt          out  16     saturating count of dropped (dst!=MY_ID) beats
//  src_err           out  1      sticky: src changed inside a word
// BEHAVIOUR
//  Reset (arstn=0, async):
//   - beat counter = 0, and any partial word is discarded.
//   - skid buffer is emptied, so out_stream_tvalid=0.
//   - out_stream_tdata=0, out_src=0, drop_cnt=0, src_err=0.
//   - lii_in_tready=0 while in reset; it goes to 1 on the first clock after release.
//  Handshake:
//   - lii_in_tready = !buf_full. It is registered, with no combinational path from out_stream_tready.
//   - A beat transfers on tvalid&tready. The dst check applies only to transferred beats.
//  Filtering:
//   - A transferred beat with dst!=MY_ID is dropped. It does not advance the counter.
//   - drop_cnt increments by 1 and saturates at 16'hFFFF.
//  Assembly (states: IDLE cnt==0, COLLECT 0<cnt<NBEAT):
//   - Beat k is written to word bits [k*PW +: PW].
//   - The last beat is truncated to DW-(NBEAT-1)*PW bits.
//   - The first beat latches its src into out_src.
//   - A later beat whose src differs from the latched src sets src_err. The beat is still used.
//   - On beat NBEAT-1, the counter wraps to 0 and the word is pushed into the 2-entry skid buffer.
//  Latency:
//   - out_stream_tvalid rises 1 cycle after the last beat is accepted.
//   - Sustained throughput is 1 beat/cycle when out_stream_tready=1.
//  Output:
//   - AXI rules apply. Once tvalid=1, tdata and out_src hold until tready. tvalid never drops without a transfer.
//  Full:
//   - The buffer holds 2 words, so tready can deassert one beat late without loss.
//   - lii_in_tready=0 exactly when the buffer holds 2 words.
//  Simultaneous events:
//   - A push and a pop in the same cycle keep the occupancy unchanged. Order is preserved.
//   - A dropped beat and the push of a completed word cannot coincide, because they are different beats.
//  Reset mid-word: the partial word is lost, and nothing is emitted for it.
// STRUCTURE
//  Package lii_pkg:
//   - LII_ID_W=8 and the lii_beat_t struct {data, src, dst}.
//   - function nbeat(dw,pw).
//  One sub-module: lii_skid_buf (2-entry, DW+8 wide, registered ready).
//  The counter, shift/insert logic, filter and statistics live in the top module.
// TESTING
//  1. Reset release, 6 beats 64'h0..05 with dst=01, src=03, tready=1
//     -> one word {..05,..04,..,..00}, out_src=03, tvalid 1 cycle after beat 5.
//  2. 12 back-to-back beats, tready=1 -> 2 words on consecutive 6-cycle boundaries, lii_in_tready stays 1.
//  3. tready=0, send 18 beats -> lii_in_tready=0 after the 12th beat.
//     Release tready -> 3 words delivered in order with no data loss.
//  4. Beats interleaved with dst=02 beats (3 of them) -> those are dropped.
//     drop_cnt=3, and the word is built from dst=01 beats only.
//  5. 70000 beats with dst=02 -> drop_cnt saturates at 16'hFFFF. No word is emitted.
//  6. The 3rd beat has src=04 -> src_err=1 and stays 1, word still delivered.
//     Assert arstn after 2 beats of the next word -> no output.
//     The following 6 beats form a clean word.

Source files
------------

// File: rtl/lii_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lii_pkg: shared LII beat types and width helpers                     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package lii_pkg;

    localparam int LII_ID_W = 8;
    localparam int LII_PW   = 64;

    typedef struct packed {
        logic [LII_PW-1:0]   data;
        logic [LII_ID_W-1:0] src;
        logic [LII_ID_W-1:0] dst;
    } lii_beat_t;

    function automatic int nbeat(input int dw, input int pw);
        return (dw + pw - 1) / pw;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lii_skid_buf.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lii_skid_buf: 2-entry output buffer with a registered input ready    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module lii_skid_buf #(
    parameter int W = 392
) (
    input  logic         aclk,
    input  logic         arstn,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);

    logic [W-1:0] mem_q [2];
    logic [W-1:0] mem_d [2];
    logic         rd_ptr_q, rd_ptr_d;
    logic         wr_ptr_q, wr_ptr_d;
    logic [1:0]   count_q,  count_d;
    logic         in_ready_q, in_ready_d;
    logic         push, pop;

    assign in_ready  = in_ready_q;
    assign out_valid = (count_q != 2'd0);
    assign out_data  = mem_q[rd_ptr_q];

    always_comb begin
        mem_d      = mem_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        push       = in_valid && in_ready_q;
        pop        = out_valid && out_ready;
        if (push) begin
            mem_d[wr_ptr_q] = in_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d    = count_q + {1'b0, push} - {1'b0, pop};
        // Ready is computed from next occupancy so it never depends on out_ready combinationally.
        in_ready_d = (count_d != 2'd2);
    end

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            mem_q[0]   <= '0;
            mem_q[1]   <= '0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            in_ready_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            in_ready_q <= in_ready_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/lii_rx_reassembler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lii_rx_reassembler: filters LII beats by dst and packs NBEAT beats   |
// | into one kernel word on an AXI-Stream style output. Rev 1.0          |
// +----------------------------------------------------------------------+
module lii_rx_reassembler
    import lii_pkg::*;
#(
    parameter int                  PW    = LII_PW,
    parameter int                  DW    = 384,
    parameter logic [LII_ID_W-1:0] MY_ID = 8'h01
) (
    input  logic                aclk,
    input  logic                arstn,
    input  logic [PW-1:0]       lii_in_tdata,
    input  logic                lii_in_tvalid,
    output logic                lii_in_tready,
    input  logic [LII_ID_W-1:0] lii_in_src,
    input  logic [LII_ID_W-1:0] lii_in_dst,
    output logic [DW-1:0]       out_stream_tdata,
    output logic                out_stream_tvalid,
    input  logic                out_stream_tready,
    output logic [LII_ID_W-1:0] out_src,
    output logic [15:0]         drop_cnt,
    output logic                src_err
);

    localparam int            NBEAT    = nbeat(DW, PW);
    localparam int            WIDE_W   = NBEAT * PW;
    localparam int            CW       = (NBEAT > 1) ? $clog2(NBEAT) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(NBEAT - 1);

    lii_beat_t             beat;
    logic                  accept, keep, drop;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DW-1:0]         word_q, word_d;
    logic [WIDE_W-1:0]     wide;
    logic [LII_ID_W-1:0]   lock_src_q, lock_src_d;
    logic [LII_ID_W-1:0]   word_src;
    logic [15:0]           drop_cnt_q, drop_cnt_d;
    logic                  src_err_q, src_err_d;
    logic                  push;

    assign beat   = '{data: lii_in_tdata, src: lii_in_src, dst: lii_in_dst};
    assign accept = lii_in_tvalid && lii_in_tready;
    assign keep   = accept && (beat.dst == MY_ID);
    assign drop   = accept && (beat.dst != MY_ID);

    assign drop_cnt = drop_cnt_q;
    assign src_err  = src_err_q;

    always_comb begin
        cnt_d      = cnt_q;
        lock_src_d = lock_src_q;
        drop_cnt_d = drop_cnt_q;
        src_err_d  = src_err_q;
        push       = 1'b0;
        // Insert into a beat-aligned view; bits above DW fall away, truncating the last beat.
        wide       = WIDE_W'(word_q);
        word_src   = (cnt_q == '0) ? beat.src : lock_src_q;
        if (keep) begin
            wide[cnt_q*PW +: PW] = beat.data;
            if (cnt_q == '0) begin
                lock_src_d = beat.src;
            end else if (beat.src != lock_src_q) begin
                src_err_d = 1'b1;
            end
            if (cnt_q == LAST_IDX) begin
                cnt_d = '0;
                push  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        word_d = wide[DW-1:0];
        if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            cnt_q      <= '0;
            word_q     <= '0;
            lock_src_q <= '0;
            drop_cnt_q <= '0;
            src_err_q  <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            word_q     <= word_d;
            lock_src_q <= lock_src_d;
            drop_cnt_q <= drop_cnt_d;
            src_err_q  <= src_err_d;
        end
    end

    lii_skid_buf #(
        .W (DW + LII_ID_W)
    ) u_skid (
        .aclk      (aclk),
        .arstn     (arstn),
        .in_data   ({word_src, word_d}),
        .in_valid  (push),
        .in_ready  (lii_in_tready),
        .out_data  ({out_src, out_stream_tdata}),
        .out_valid (out_stream_tvalid),
        .out_ready (out_stream_tready)
    );

endmodule
`default_nettype wire

// File: tb/tb_lii_rx_reassembler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_lii_rx_reassembler: directed scoreboard bench for the reassembler |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_lii_rx_reassembler;

    logic         aclk = 1'b0;
    logic         arstn;
    logic [63:0]  lii_in_tdata;
    logic         lii_in_tvalid;
    logic         lii_in_tready;
    logic [7:0]   lii_in_src;
    logic [7:0]   lii_in_dst;
    logic [383:0] out_stream_tdata;
    logic         out_stream_tvalid;
    logic         out_stream_tready;
    logic [7:0]   out_src;
    logic [15:0]  drop_cnt;
    logic         src_err;

    int n_checks = 0;
    int n_fail   = 0;
    int stalls   = 0;

    logic [391:0] exp_q [$];
    logic [383:0] m_word;
    logic [7:0]   m_src;
    int           m_cnt  = 0;
    logic [15:0]  m_drop = 16'h0;

    lii_rx_reassembler dut (
        .aclk              (aclk),
        .arstn             (arstn),
        .lii_in_tdata      (lii_in_tdata),
        .lii_in_tvalid     (lii_in_tvalid),
        .lii_in_tready     (lii_in_tready),
        .lii_in_src        (lii_in_src),
        .lii_in_dst        (lii_in_dst),
        .out_stream_tdata  (out_stream_tdata),
        .out_stream_tvalid (out_stream_tvalid),
        .out_stream_tready (out_stream_tready),
        .out_src           (out_src),
        .drop_cnt          (drop_cnt),
        .src_err           (src_err)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [391:0] obs, input logic [391:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one beat, wait until it is accepted, then update the reference model.
    task automatic send(input logic [63:0] d, input logic [7:0] s, input logic [7:0] dst);
        int n = 0;
        lii_in_tdata  = d;
        lii_in_src    = s;
        lii_in_dst    = dst;
        lii_in_tvalid = 1'b1;
        @(negedge aclk);
        while (!lii_in_tready && n < 200) begin
            @(negedge aclk);
            n++;
        end
        stalls += n;
        if (n >= 200) begin
            n_checks++;
            assert (0) else begin
                n_fail++;
                $error("FAIL beat_timeout: observed no ready in %0d cycles, expected ready", n);
            end
        end else begin
            @(posedge aclk);
            #1;
            if (dst == 8'h01) begin
                if (m_cnt == 0) m_src = s;
                m_word[m_cnt*64 +: 64] = d;
                m_cnt++;
                if (m_cnt == 6) begin
                    exp_q.push_back({m_src, m_word});
                    m_cnt = 0;
                end
            end else if (m_drop != 16'hFFFF) begin
                m_drop++;
            end
        end
    endtask

    task automatic idle(input int cycles);
        lii_in_tvalid = 1'b0;
        repeat (cycles) @(posedge aclk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        lii_in_tvalid = 1'b0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge aclk);
            n++;
        end
        #1;
        check("drain_empty", 392'(exp_q.size()), 392'd0);
    endtask

    // Output monitor: pops expected words on handshakes and checks AXI hold behaviour.
    logic [391:0] hold_val;
    logic         hold_pend = 1'b0;
    always @(negedge aclk) begin
        if (arstn === 1'b1) begin
            if (hold_pend) begin
                check("axi_hold_valid", 392'(out_stream_tvalid), 392'd1);
                check("axi_hold_data", {out_src, out_stream_tdata}, hold_val);
            end
            hold_pend = out_stream_tvalid && !out_stream_tready;
            hold_val  = {out_src, out_stream_tdata};
            if (out_stream_tvalid && out_stream_tready) begin
                n_checks++;
                assert (exp_q.size() != 0) else begin
                    n_fail++;
                    $error("FAIL unexpected_word: observed %0h expected no word", out_stream_tdata);
                end
                if (exp_q.size() != 0) begin
                    logic [391:0] e;
                    e = exp_q.pop_front();
                    check("word", {out_src, out_stream_tdata}, e);
                end
            end
        end else begin
            hold_pend = 1'b0;
        end
    end

    initial begin
        arstn             = 1'b0;
        lii_in_tvalid     = 1'b0;
        lii_in_tdata      = '0;
        lii_in_src        = '0;
        lii_in_dst        = '0;
        out_stream_tready = 1'b1;
        m_word            = '0;
        m_src             = '0;
        repeat (3) @(posedge aclk);
        #1;
        check("rst_tvalid", 392'(out_stream_tvalid), 392'd0);
        check("rst_tdata", 392'(out_stream_tdata), 392'd0);
        check("rst_out_src", 392'(out_src), 392'd0);
        check("rst_drop_cnt", 392'(drop_cnt), 392'd0);
        check("rst_src_err", 392'(src_err), 392'd0);
        check("rst_in_ready", 392'(lii_in_tready), 392'd0);
        arstn = 1'b1;
        #1;
        check("release_ready_low", 392'(lii_in_tready), 392'd0);
        @(posedge aclk);
        #1;
        check("release_ready_high", 392'(lii_in_tready), 392'd1);

        // 1: single word, latency
        for (int i = 0; i < 6; i++) begin
            send(64'(i), 8'h03, 8'h01);
            if (i == 4) check("t1_valid_before", 392'(out_stream_tvalid), 392'd0);
            if (i == 5) check("t1_valid_after", 392'(out_stream_tvalid), 392'd1);
        end
        drain();

        // 2: back-to-back words
        stalls = 0;
        for (int i = 0; i < 12; i++) begin
            send(64'h100 + 64'(i), 8'h03, 8'h01);
            if (i == 5 || i == 11) check("t2_valid_word", 392'(out_stream_tvalid), 392'd1);
            if (i == 6) check("t2_valid_popped", 392'(out_stream_tvalid), 392'd0);
        end
        check("t2_no_stall", 392'(stalls), 392'd0);
        check("t2_ready", 392'(lii_in_tready), 392'd1);
        drain();

        // 3: backpressure fills the buffer
        out_stream_tready = 1'b0;
        for (int i = 0; i < 12; i++) send({$urandom, $urandom}, 8'h05, 8'h01);
        check("t3_ready_full", 392'(lii_in_tready), 392'd0);
        fork
            for (int i = 0; i < 6; i++) send({$urandom, $urandom}, 8'h05, 8'h01);
            begin
                repeat (8) @(posedge aclk);
                #1;
                out_stream_tready = 1'b1;
            end
        join
        drain();

        // 4: foreign beats interleaved
        begin
            logic [7:0] pat [9] = '{8'h01, 8'h02, 8'h01, 8'h01, 8'h02, 8'h01, 8'h02, 8'h01, 8'h01};
            for (int i = 0; i < 9; i++) send(64'hA000 + 64'(i), 8'h07, pat[i]);
        end
        drain();
        check("t4_drop_cnt", 392'(drop_cnt), 392'(m_drop));
        check("t4_drop_3", 392'(drop_cnt), 392'd3);

        // 5: drop counter saturation
        for (int i = 0; i < 70000; i++) send(64'(i), 8'h03, 8'h02);
        idle(2);
        check("t5_drop_sat", 392'(drop_cnt), 392'h0FFFF);
        check("t5_no_word", 392'(out_stream_tvalid), 392'd0);

        // 6: source change, then reset mid-word
        for (int i = 0; i < 6; i++) send(64'hB0 + 64'(i), (i == 2) ? 8'h04 : 8'h03, 8'h01);
        check("t6_src_err", 392'(src_err), 392'd1);
        drain();
        send(64'hC0, 8'h03, 8'h01);
        send(64'hC1, 8'h03, 8'h01);
        check("t6_src_err_sticky", 392'(src_err), 392'd1);
        lii_in_tvalid = 1'b0;
        arstn         = 1'b0;
        m_cnt         = 0;
        m_drop        = 16'h0;
        #1;
        check("t6_rst_err", 392'(src_err), 392'd0);
        check("t6_rst_drop", 392'(drop_cnt), 392'd0);
        check("t6_rst_valid", 392'(out_stream_tvalid), 392'd0);
        check("t6_rst_ready", 392'(lii_in_tready), 392'd0);
        repeat (2) @(posedge aclk);
        #1;
        arstn = 1'b1;
        @(posedge aclk);
        #1;
        check("t6_ready_after_rst", 392'(lii_in_tready), 392'd1);
        for (int i = 0; i < 6; i++) send(64'hD0 + 64'(i), 8'h09, 8'h01);
        drain();
        check("t6_clean_err", 392'(src_err), 392'd0);
        idle(3);
        check("t6_idle_valid", 392'(out_stream_tvalid), 392'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
